rw_burst_arbiter: RTL and testbench
===================================

// Module: rw_burst_arbiter
// PURPOSE
//  Shares the single cache datapath port between the read-channel and write-channel requesters.
//  - Round-robin arbitration between the two requesters.
//  - Grant is locked for the whole burst of one requester.
//  - Read data is zero-extended onto the wide output bus.
//  - Tags each beat with the served direction and a last-beat flag.
//  - Sits between the AXI-MM channel front ends and the cache lookup/fill pipeline.
// PARAMETERS
//  R_WIDTH  32  read data width; must be <= W_WIDTH
//  W_WIDTH  64  write/output data width
//  LEN_W    4   burst length field width; len = beats-1, so max burst is 2**LEN_W beats
// PORTS
//  clk            in   1        single clock, rising edge
//  rst            in   1        synchronous active-low reset
//  rdata          in   R_WIDTH  read requester beat data
//  r_valid        in   1        read beat valid
//  r_len          in   LEN_W    read burst beats-1; stable while r_valid=1 before grant
//  r_ready        out  1        read beat accepted when r_valid&r_ready
//  wdata          in   W_WIDTH  write requester beat data
//  w_valid        in   1        write beat valid
//  w_len          in   LEN_W    write burst beats-1
//  w_ready        out  1        write beat accepted when w_valid&w_ready
//  out_data       out  W_WIDTH  granted beat; read data zero-extended
//  out_valid      out  1        output beat valid
//  out_ready      in   1        downstream accepts beat
//  read_or_write  out  1        0 = read beat, 1 = write beat
//  out_last       out  1        final beat of the granted burst
// BEHAVIOUR
//  State machine states: IDLE, READ, WRITE.
//  - Reset (rst=0 at an edge): state=IDLE, last_served=1 so read wins the first tie, beat_cnt=0.
//    All outputs are 0.
//  - Reset mid-burst: the burst is abandoned with no completion, and the next cycle is IDLE.
//  - IDLE grant selection:
//    - r_valid & !w_valid -> READ.
//    - !r_valid & w_valid -> WRITE.
//    - both valid -> READ if last_served=1, else WRITE.
//    - neither valid -> stay in IDLE.
//  - On the IDLE decision edge, the granted len is latched into burst_len and beat_cnt is cleared.
//  - The IDLE cycle moves no data and both readies are 0, so each burst costs one bubble cycle.
//  - READ/WRITE handshake:
//    - out_valid = selected valid; selected ready = out_ready; the other ready is 0.
//    - out_data = selected data; read_or_write = granted direction.
//    - Valid/ready are combinational pass-through; valid never depends on ready.
//  - Each out_valid&out_ready: beat_cnt increments; out_last=1 when beat_cnt==burst_len.
//  - Handshake on the last beat: last_served <= direction served, next state = IDLE.
//  - beat_cnt is LEN_W bits; it never wraps because the burst ends at burst_len.
//  - len=0 gives a single beat with out_last=1 on the first beat.
//  - Requester drops valid mid-burst: out_valid=0 and the state holds.
//    There is no timeout and the grant is never stolen.
//  - A non-granted requester waits with ready=0 and never loses an asserted request.
//    Worst-case wait is one full burst of the other requester.
//  - Back-to-back bursts from one requester with the other idle: the same requester is re-granted after the IDLE bubble.
// CONFIGURATION
//  RW_ARB_OUT_REG_EN
//  - Defined: out_* pass through a 2-entry skid register slice.
//    - Output latency is +1 cycle at full throughput.
//    - Selected ready = slice not full; out_data/out_valid/read_or_write/out_last are registered.
//    - burst_len/beat_cnt still count input-side handshakes.
//    - Reset empties the slice, so out_valid=0.
//  - Undefined: combinational path exactly as described above, with zero added latency.
// STRUCTURE
//  Package rw_arb_pkg:
//  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_READ, ARB_WRITE}.
//  - localparams GNT_READ=1'b0 and GNT_WRITE=1'b1.
//  - Default R_WIDTH=32 and W_WIDTH=64.
//  Sub-module rw_arb_skid (W_WIDTH+2 payload, valid/ready skid) is instantiated only under RW_ARB_OUT_REG_EN.
// TESTING
//  - Reset release, both valid, r_len=0, w_len=0, out_ready=1:
//    - First output: read beat, out_last=1.
//    - After a bubble: write beat, out_last=1.
//    - Then read again.
//  - r_valid only, r_len=3, rdata=32'hA5A5_0001..4:
//    - 4 beats with out_data=64'h0000_0000_A5A5_000n and read_or_write=0.
//    - out_last only on the 4th beat.
//  - Write burst w_len=2 with out_ready low on cycles 2-3:
//    - Beats hold stable with w_ready=0 and no beat lost.
//    - r_valid is asserted throughout, and r_ready stays 0 until the write burst completes.
//  - w_valid drops for 2 cycles mid-burst:
//    - out_valid=0 during the gap, state stays WRITE, and the burst then completes.
//  - rst=0 asserted during beat 2 of a read burst of length 4:
//    - The next cycle has all outputs 0.
//    - After release with both valid, read is granted because last_served was reset to 1.
//  - RW_ARB_OUT_REG_EN defined: repeat test 2; the same beat sequence appears with +1 cycle latency and no throughput loss.

Source files
------------

// File: rtl/rw_arb_pkg.sv
// Shared types and constants for the read/write burst arbiter.
//   arb_state_t : grant state (idle, read burst, write burst)
//   GNT_READ / GNT_WRITE : encoding of the served direction (read_or_write, last_served)
//   DEF_* : default widths for the arbiter and its testbench
package rw_arb_pkg;

    localparam int unsigned DEF_R_WIDTH = 32;
    localparam int unsigned DEF_W_WIDTH = 64;
    localparam int unsigned DEF_LEN_W   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_READ  = 2'd1,
        ARB_WRITE = 2'd2
    } arb_state_t;

    localparam logic GNT_READ  = 1'b0;
    localparam logic GNT_WRITE = 1'b1;

endpackage

// File: rtl/rw_arb_skid.sv
// Two-entry valid/ready register slice. Accepts a new word whenever it is
// not full, so a continuous stream passes at full rate with one cycle of latency.
//   clk, rst   : clock, synchronous active-low reset (empties the slice)
//   i_data/i_valid/o_ready : upstream side
//   o_data/o_valid/i_ready : downstream side (o_data is the head register)
module rw_arb_skid #(
    parameter int unsigned WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_buf0;
    logic [WIDTH-1:0] r_buf1;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_buf0;
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    // r_buf0 is always the head; r_buf1 only holds a word while the head is stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= 2'd0;
            r_buf0  <= '0;
            r_buf1  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_buf0 <= i_data;
                    else                 r_buf1 <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_buf0  <= r_buf1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_buf0 <= i_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rw_burst_arbiter.sv
// Round-robin arbiter sharing one cache datapath port between a read and a
// write requester; the grant is held for a whole burst.
//   clk, rst                        : clock, synchronous active-low reset
//   rdata/r_valid/r_len/r_ready     : read requester (data zero-extended on output)
//   wdata/w_valid/w_len/w_ready     : write requester
//   out_data/out_valid/out_ready    : granted beat stream to the cache pipeline
//   read_or_write, out_last         : beat tags (0 = read, 1 = write; final beat)
// Build option RW_ARB_OUT_REG_EN: registers the output stream through a
// two-entry skid slice (+1 cycle latency); undefined gives a combinational path.
module rw_burst_arbiter
    import rw_arb_pkg::*;
#(
    parameter int unsigned R_WIDTH = DEF_R_WIDTH,
    parameter int unsigned W_WIDTH = DEF_W_WIDTH,
    parameter int unsigned LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [R_WIDTH-1:0] rdata,
    input  logic               r_valid,
    input  logic [LEN_W-1:0]   r_len,
    output logic               r_ready,
    input  logic [W_WIDTH-1:0] wdata,
    input  logic               w_valid,
    input  logic [LEN_W-1:0]   w_len,
    output logic               w_ready,
    output logic [W_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               read_or_write,
    output logic               out_last
);

    arb_state_t         r_state;
    logic [LEN_W-1:0]   r_burst_len;
    logic [LEN_W-1:0]   r_beat_cnt;
    logic               r_last_served;

    logic               w_active;
    logic               w_sel_valid;
    logic               w_sel_ready;
    logic [W_WIDTH-1:0] w_sel_data;
    logic               w_dir;
    logic               w_last;
    logic               w_hs;

    assign w_active = (r_state != ARB_IDLE);
    assign w_last   = w_active && (r_beat_cnt == r_burst_len);
    assign w_hs     = w_sel_valid & w_sel_ready;
    assign r_ready  = (r_state == ARB_READ)  & w_sel_ready;
    assign w_ready  = (r_state == ARB_WRITE) & w_sel_ready;

    // Mux the granted requester onto the internal beat stream; idle drives zeros.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_dir       = GNT_READ;
        case (r_state)
            ARB_READ: begin
                w_sel_valid = r_valid;
                w_sel_data  = W_WIDTH'(rdata);
                w_dir       = GNT_READ;
            end
            ARB_WRITE: begin
                w_sel_valid = w_valid;
                w_sel_data  = wdata;
                w_dir       = GNT_WRITE;
            end
            default: ;
        endcase
    end

    // Grant FSM: round-robin pick in IDLE, lock until the last beat handshakes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ARB_IDLE;
            r_last_served <= GNT_WRITE;
            r_beat_cnt    <= '0;
            r_burst_len   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (r_valid && (!w_valid || (r_last_served == GNT_WRITE))) begin
                        r_state     <= ARB_READ;
                        r_burst_len <= r_len;
                        r_beat_cnt  <= '0;
                    end else if (w_valid) begin
                        r_state     <= ARB_WRITE;
                        r_burst_len <= w_len;
                        r_beat_cnt  <= '0;
                    end
                end
                ARB_READ, ARB_WRITE: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_state       <= ARB_IDLE;
                            r_last_served <= w_dir;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

`ifdef RW_ARB_OUT_REG_EN
    logic [W_WIDTH+1:0] w_skid_out;
    logic               w_skid_in_ready;

    // Payload packs {direction, last, data}; beat counting stays on the input side.
    rw_arb_skid #(
        .WIDTH (W_WIDTH + 2)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  ({w_dir, w_last, w_sel_data}),
        .i_valid (w_sel_valid),
        .o_ready (w_skid_in_ready),
        .o_data  (w_skid_out),
        .o_valid (out_valid),
        .i_ready (out_ready)
    );

    assign w_sel_ready   = w_active & w_skid_in_ready;
    assign read_or_write = w_skid_out[W_WIDTH+1];
    assign out_last      = w_skid_out[W_WIDTH];
    assign out_data      = w_skid_out[W_WIDTH-1:0];
`else
    assign w_sel_ready   = w_active & out_ready;
    assign out_valid     = w_sel_valid;
    assign out_data      = w_sel_data;
    assign read_or_write = w_dir;
    assign out_last      = w_last;
`endif

endmodule

// File: tb/tb_rw_burst_arbiter.sv
// Scoreboard bench for rw_burst_arbiter: requester drivers issue bursts, a
// reference model orders the expected beats by round-robin and a monitor
// compares each accepted output beat against that queue.
module tb_rw_burst_arbiter;

    localparam int unsigned RW = 32;
    localparam int unsigned WW = 64;
    localparam int unsigned LW = 4;
    localparam int HS_BUDGET   = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] rdata;
    logic          r_valid;
    logic [LW-1:0] r_len;
    logic          r_ready;
    logic [WW-1:0] wdata;
    logic          w_valid;
    logic [LW-1:0] w_len;
    logic          w_ready;
    logic [WW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          read_or_write;
    logic          out_last;

    always #5 clk = ~clk;

    rw_burst_arbiter #(.R_WIDTH(RW), .W_WIDTH(WW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .rdata(rdata), .r_valid(r_valid), .r_len(r_len), .r_ready(r_ready),
        .wdata(wdata), .w_valid(w_valid), .w_len(w_len), .w_ready(w_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .read_or_write(read_or_write), .out_last(out_last)
    );

    int checks = 0;
    int fails  = 0;

    // Pending bursts per requester, flattened per beat (len stored per burst).
    int            rl[$];
    logic [RW-1:0] rd[$];
    int            rg[$];
    int            wl[$];
    logic [WW-1:0] wd[$];
    int            wg[$];

    logic [WW+1:0] exp_q[$];
    bit            model_ls  = 1'b1;
    int            or_mode   = 0;
    int            phase_cyc = 0;
    bit            t3_watch  = 1'b0;

    function automatic void add_rd(input int len, input logic [RW-1:0] base, input bit rnd);
        rl.push_back(len);
        for (int i = 0; i <= len; i++) begin
            rd.push_back(rnd ? RW'($urandom) : base + RW'(i));
            rg.push_back((rnd && i > 0 && $urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0);
        end
    endfunction

    function automatic void add_wr(input int len, input logic [WW-1:0] base, input bit rnd);
        wl.push_back(len);
        for (int i = 0; i <= len; i++) begin
            wd.push_back(rnd ? {$urandom, $urandom} : base + WW'(i));
            wg.push_back((rnd && i > 0 && $urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0);
        end
    endfunction

    // Both requesters keep a burst pending back to back, so the served order is a
    // plain alternation starting from whoever was not served last.
    function automatic void build_expected();
        int ri = 0, wi = 0, rb = 0, wb = 0;
        while (ri < rl.size() || wi < wl.size()) begin
            bit pick_w;
            if (ri < rl.size() && wi < wl.size()) pick_w = (model_ls == 1'b0);
            else                                  pick_w = (wi < wl.size());
            if (!pick_w) begin
                for (int i = 0; i <= rl[ri]; i++)
                    exp_q.push_back({1'b0, (i == rl[ri]), WW'(rd[rb + i])});
                rb += rl[ri] + 1;
                ri++;
                model_ls = 1'b0;
            end else begin
                for (int i = 0; i <= wl[wi]; i++)
                    exp_q.push_back({1'b1, (i == wl[wi]), wd[wb + i]});
                wb += wl[wi] + 1;
                wi++;
                model_ls = 1'b1;
            end
        end
    endfunction

    task automatic check_gap();
`ifndef RW_ARB_OUT_REG_EN
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL gap_out_valid: got %b expected 0", out_valid);
        end
`endif
    endtask

    task automatic rd_hs(output bit ok);
        bit hs;
        int waited;
        hs = 1'b0;
        waited = 0;
        while (!hs && waited < HS_BUDGET) begin
            @(negedge clk);
            hs = r_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        ok = hs;
        if (!hs) begin
            checks++;
            fails++;
            $display("FAIL rd_handshake: r_ready stayed 0, expected 1 within %0d cycles", HS_BUDGET);
        end
    endtask

    task automatic wr_hs(output bit ok);
        bit hs;
        int waited;
        hs = 1'b0;
        waited = 0;
        while (!hs && waited < HS_BUDGET) begin
            @(negedge clk);
            hs = w_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        ok = hs;
        if (!hs) begin
            checks++;
            fails++;
            $display("FAIL wr_handshake: w_ready stayed 0, expected 1 within %0d cycles", HS_BUDGET);
        end
    endtask

    task automatic drive_rd();
        int p = 0;
        bit ok;
        for (int b = 0; b < rl.size(); b++) begin
            for (int i = 0; i <= rl[b]; i++) begin
                if (rg[p] > 0) begin
                    r_valid = 1'b0;
                    repeat (rg[p]) begin
                        @(negedge clk);
                        check_gap();
                        @(posedge clk);
                        #1;
                    end
                end
                r_valid = 1'b1;
                r_len   = LW'(rl[b]);
                rdata   = rd[p];
                rd_hs(ok);
                if (!ok) begin
                    r_valid = 1'b0;
                    return;
                end
                p++;
            end
        end
        r_valid = 1'b0;
    endtask

    task automatic drive_wr();
        int p = 0;
        bit ok;
        for (int b = 0; b < wl.size(); b++) begin
            for (int i = 0; i <= wl[b]; i++) begin
                if (wg[p] > 0) begin
                    w_valid = 1'b0;
                    repeat (wg[p]) begin
                        @(negedge clk);
                        check_gap();
                        @(posedge clk);
                        #1;
                    end
                end
                w_valid = 1'b1;
                w_len   = LW'(wl[b]);
                wdata   = wd[p];
                wr_hs(ok);
                if (!ok) begin
                    w_valid = 1'b0;
                    return;
                end
                p++;
            end
        end
        w_valid = 1'b0;
    endtask

    task automatic run_phase(input int mode);
        build_expected();
        or_mode   = mode;
        phase_cyc = 0;
        fork
            drive_rd();
            begin
                drive_wr();
                t3_watch = 1'b0;
            end
        join
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d beats still outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        rl.delete(); rd.delete(); rg.delete();
        wl.delete(); wd.delete(); wg.delete();
        or_mode = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        logic [WW+4:0] got;
        got = {r_ready, w_ready, out_valid, read_or_write, out_last, out_data};
        checks++;
        if (got !== '0) begin
            fails++;
            $display("FAIL %s: outputs {r_ready,w_ready,out_valid,rw,last,data}=%h expected 0", tag, got);
        end
    endtask

    // Downstream ready pattern generator.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            phase_cyc++;
            case (or_mode)
                1:       out_ready = ($urandom_range(3) != 0);
                2:       out_ready = !(phase_cyc == 3 || phase_cyc == 4);
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pop and compare on every accepted output beat.
    logic [WW+1:0] mon_got;
    logic [WW+1:0] mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (rst && t3_watch) begin
                checks++;
                if (r_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL r_ready_during_write: got %b expected 0", r_ready);
                end
            end
            if (rst && out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                mon_got = {read_or_write, out_last, out_data};
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got %h expected no beat", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        fails++;
                        $display("FAIL beat {rw,last,data}: got %h expected %h", mon_got, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        bit ok;
        int nr;
        int nw;
        rst = 1'b0;
        rdata = '0; r_valid = 1'b0; r_len = '0;
        wdata = '0; w_valid = 1'b0; w_len = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_outputs");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single-beat bursts from both: read, write, read
        add_rd(0, 32'h0000_0011, 1'b0);
        add_rd(0, 32'h0000_0022, 1'b0);
        add_wr(0, 64'h0000_0000_0000_0033, 1'b0);
        run_phase(0);

        // Read-only 4-beat burst, zero-extended data
        add_rd(3, 32'hA5A5_0001, 1'b0);
        run_phase(0);

        // Write burst with downstream stalls while read waits
        add_wr(2, 64'hBEEF_0000_0000_0000, 1'b0);
        add_rd(0, 32'h0000_0077, 1'b0);
        t3_watch = 1'b1;
        run_phase(2);

        // Write requester drops valid for two cycles mid-burst
        add_wr(3, 64'hC0DE_0000_0000_0000, 1'b0);
        wg[wg.size() - 2] = 2;
        run_phase(0);

        // Serve a read last so that reset, not history, decides the next tie
        add_rd(0, 32'h0000_0099, 1'b0);
        run_phase(0);

        // Reset during beat 2 of a 4-beat read burst
        exp_q.push_back({1'b0, 1'b0, WW'(32'hD00D_0000)});
        r_len   = LW'(3);
        rdata   = 32'hD00D_0000;
        r_valid = 1'b1;
        rd_hs(ok);
        rdata = 32'hD00D_0001;
        rst   = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        r_valid = 1'b0;
        @(negedge clk);
        check_zero("outputs_after_midburst_reset");
        exp_q.delete();
        model_ls = 1'b1;
        @(posedge clk);
        #1;
        add_rd(0, 32'h0000_00AA, 1'b0);
        add_wr(0, 64'h0000_0000_0000_00BB, 1'b0);
        run_phase(0);

        // Randomized traffic with random stalls and mid-burst gaps
        for (int k = 0; k < 6; k++) begin
            nr = int'($urandom_range(4, 1));
            nw = int'($urandom_range(4, 0));
            for (int i = 0; i < nr; i++) add_rd(int'($urandom_range(15)), '0, 1'b1);
            for (int i = 0; i < nw; i++) add_wr(int'($urandom_range(15)), '0, 1'b1);
            run_phase(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
